// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//   Bundle of signals between the multi-cycle MIPS controller and its datapath
//   and shared memory.
//   master : the controller. It takes opcode/zero/mem_ready and drives the
//            mux selects, ALU op class, write enables and status pulses.
//   slave  : the datapath/memory side. It drives opcode/zero/mem_ready and
//            receives the controls.
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_en;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal_op;
   logic       bus_err;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsrc, state, instr_done,
             illegal_op, bus_err
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsrc, state, instr_done,
             illegal_op, bus_err
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath that shares one memory for
//   instructions and data. Per state it drives mux selects, the ALU op class
//   and write enables. Memory states (FETCH, MEMRD, MEMWR) are stretched until
//   mem_ready; a stalled access raises a one-cycle bus_err after TIMEOUT wait
//   cycles (data accesses abort to FETCH, FETCH retries).
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous reset, active low
//     bus  : mips_multicycle_ctrl_if.master (opcode/zero/mem_ready in,
//            datapath controls, state code and status pulses out)
//
//   Parameters
//     CNT_W   : wait-counter width
//     TIMEOUT : wait cycles without mem_ready before bus_err (<= 2**CNT_W-1)
//
//   Configuration
//     MIPS_CTRL_JUMP_EN : when defined, opcode 2 (j) executes through the
//                         JUMP state; otherwise it is reported as illegal.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   mips_multicycle_ctrl_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
`ifdef MIPS_CTRL_JUMP_EN
   localparam logic [5:0] OP_J     = 6'd2;
`endif
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg;
   logic       regwrite, alusrca, instr_done, illegal_op, bus_err;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       timeout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // counter reaches TIMEOUT while the access is still outstanding
   assign timeout = (cnt_q == TO);

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      pc_en      = 1'b0;
      iord       = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      bus_err    = 1'b0;

      case (state_q)
         S_FETCH: begin
            // PC+4 computed by the ALU while the instruction is read
            memread = 1'b1;
            alusrcb = 2'b01;
            if (bus.mem_ready) begin
               irwrite = 1'b1;
               pc_en   = 1'b1;
               state_d = S_DECODE;
            end else if (timeout) begin
               bus_err = 1'b1;          // retry fetch with a fresh count
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            // branch target into ALUOut speculatively
            alusrcb = 2'b11;
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_LW, OP_SW: state_d = S_MEMADR;
`ifdef MIPS_CTRL_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            if (bus.opcode == OP_LW)      state_d = S_MEMRD;
            else if (bus.opcode == OP_SW) state_d = S_MEMWR;
            else                          state_d = S_FETCH;
         end
         S_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (bus.mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
            if (bus.mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (timeout) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            // ALU compares rs/rt; take the target held in ALUOut on zero
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsrc      = 2'b01;
            pc_en      = bus.zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef MIPS_CTRL_JUMP_EN
         S_JUMP: begin
            pcsrc      = 2'b10;
            pc_en      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;  // unused codes recover, outputs idle
      endcase

      // no architectural side effects while held in reset
      if (!rst) begin
         pc_en      = 1'b0;
         irwrite    = 1'b0;
         regwrite   = 1'b0;
         memwrite   = 1'b0;
         instr_done = 1'b0;
         illegal_op = 1'b0;
         bus_err    = 1'b0;
      end
   end

   assign bus.pc_en      = pc_en;
   assign bus.iord       = iord;
   assign bus.memread    = memread;
   assign bus.memwrite   = memwrite;
   assign bus.irwrite    = irwrite;
   assign bus.regdst     = regdst;
   assign bus.memtoreg   = memtoreg;
   assign bus.regwrite   = regwrite;
   assign bus.alusrca    = alusrca;
   assign bus.alusrcb    = alusrcb;
   assign bus.aluop      = aluop;
   assign bus.pcsrc      = pcsrc;
   assign bus.state      = state_q;
   assign bus.instr_done = instr_done;
   assign bus.illegal_op = illegal_op;
   assign bus.bus_err    = bus_err;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Self-checking bench for mips_multicycle_ctrl: a per-cycle vector table,
//   hand sequences for wait-state timeouts, and randomized instructions
//   checked against an instruction-level latency/strobe-count model.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_multicycle_ctrl_if bif();

   mips_multicycle_ctrl #(.CNT_W(4), .TIMEOUT(15)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   typedef struct packed {
      logic       pc_en, iord, memread, memwrite, irwrite, regdst, memtoreg;
      logic       regwrite, alusrca;
      logic [1:0] alusrcb, aluop, pcsrc;
      logic       instr_done, illegal_op, bus_err;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       z;
      logic       rdy;
      int         st;     // expected state code this cycle
      bit         chk;
   } vec_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   ctl_t act;
   int   act_st;
   vec_t vecs[$];

   task automatic check(input string name, input int a, input int e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, a, e, $time);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      bit l;
      l = (op == 6'd0) || (op == 6'd4) || (op == 6'd8) || (op == 6'd35) || (op == 6'd43);
`ifdef MIPS_CTRL_JUMP_EN
      l = l || (op == 6'd2);
`endif
      return l;
   endfunction

   // Output table straight from the state descriptions
   function automatic ctl_t spec_ctl(input int st, input logic [5:0] op,
                                     input logic z, input logic rdy, input logic r);
      ctl_t c;
      c = '0;
      case (st)
         0:  begin c.memread = 1; c.alusrcb = 2'b01; c.irwrite = rdy; c.pc_en = rdy; end
         1:  begin c.alusrcb = 2'b11; c.illegal_op = !is_legal(op); end
         2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
         3:  begin c.memread = 1; c.iord = 1; end
         4:  begin c.memtoreg = 1; c.regwrite = 1; c.instr_done = 1; end
         5:  begin c.memwrite = 1; c.iord = 1; c.instr_done = rdy; end
         6:  begin c.alusrca = 1; c.aluop = 2'b10; end
         7:  begin c.regdst = 1; c.regwrite = 1; c.instr_done = 1; end
         8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pc_en = z; c.instr_done = 1; end
         9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
         10: begin c.regwrite = 1; c.instr_done = 1; end
         11: begin c.pcsrc = 2'b10; c.pc_en = 1; c.instr_done = 1; end
         default: c = '0;
      endcase
      if (!r) begin
         c.pc_en = 0; c.irwrite = 0; c.regwrite = 0; c.memwrite = 0;
         c.instr_done = 0; c.illegal_op = 0; c.bus_err = 0;
      end
      return c;
   endfunction

   task automatic sample();
      @(negedge clk);
      act.pc_en      = bif.pc_en;      act.iord     = bif.iord;
      act.memread    = bif.memread;    act.memwrite = bif.memwrite;
      act.irwrite    = bif.irwrite;    act.regdst   = bif.regdst;
      act.memtoreg   = bif.memtoreg;   act.regwrite = bif.regwrite;
      act.alusrca    = bif.alusrca;    act.alusrcb  = bif.alusrcb;
      act.aluop      = bif.aluop;      act.pcsrc    = bif.pcsrc;
      act.instr_done = bif.instr_done; act.illegal_op = bif.illegal_op;
      act.bus_err    = bif.bus_err;
      act_st         = int'(bif.state);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic rdy);
      rst           = r;
      bif.opcode    = op;
      bif.zero      = z;
      bif.mem_ready = rdy;
   endtask

   task automatic add(input logic r, input logic [5:0] op, input logic z,
                      input logic rdy, input int st, input bit chk);
      vec_t v;
      v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.chk = chk;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      drive(1'b0, 6'd0, 1'b0, 1'b1);
      adv();
      adv();
      rst = 1'b1;
   endtask

   // Instruction-level model: latency = fixed base per opcode + wait cycles;
   // strobe counts follow from which phases the instruction goes through.
   task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
      int lf, ms, tot;
      int e_rw, e_mr, e_mw, e_pc, e_ill, e_done;
      int n_rw, n_mr, n_mw, n_pc, n_ill, n_done, n_ir, n_err;
      logic last_done;
      lf = wf + 1; ms = -1;
      e_rw = 0; e_mr = lf; e_mw = 0; e_pc = 1; e_ill = 0; e_done = 0;
      n_rw = 0; n_mr = 0; n_mw = 0; n_pc = 0; n_ill = 0; n_done = 0; n_ir = 0; n_err = 0;
      last_done = 1'b0;
      tot = lf + 1;
      if (!is_legal(op)) begin
         e_ill = 1;
      end else begin
         e_done = 1;
         case (op)
            6'd0, 6'd8: begin tot = lf + 3; e_rw = 1; end
            6'd4:       begin tot = lf + 2; e_pc = 1 + int'(z); end
            6'd2:       begin tot = lf + 2; e_pc = 2; end
            6'd35:      begin ms = lf + 2; tot = ms + wm + 2; e_mr = lf + wm + 1; e_rw = 1; end
            6'd43:      begin ms = lf + 2; tot = ms + wm + 1; e_mw = wm + 1; end
            default:    tot = lf + 1;
         endcase
      end
      for (int i = 0; i < tot; i++) begin
         logic rdy;
         if (i < lf)                                rdy = (i == wf);
         else if (ms >= 0 && i >= ms && i <= ms + wm) rdy = ((i - ms) == wm);
         else                                       rdy = 1'($urandom % 2);
         drive(1'b1, op, z, rdy);
         sample();
         if (i == 0) check($sformatf("rnd op%0d start state", op), act_st, 0);
         n_rw += int'(act.regwrite); n_mr += int'(act.memread);
         n_mw += int'(act.memwrite); n_pc += int'(act.pc_en);
         n_ill += int'(act.illegal_op); n_done += int'(act.instr_done);
         n_ir += int'(act.irwrite); n_err += int'(act.bus_err);
         if (i == tot - 1) last_done = act.instr_done;
         adv();
      end
      check($sformatf("rnd op%0d regwrite cnt", op), n_rw, e_rw);
      check($sformatf("rnd op%0d memread cnt", op), n_mr, e_mr);
      check($sformatf("rnd op%0d memwrite cnt", op), n_mw, e_mw);
      check($sformatf("rnd op%0d pc_en cnt", op), n_pc, e_pc);
      check($sformatf("rnd op%0d illegal cnt", op), n_ill, e_ill);
      check($sformatf("rnd op%0d done cnt", op), n_done, e_done);
      check($sformatf("rnd op%0d done last", op), int'(last_done), e_done);
      check($sformatf("rnd op%0d irwrite cnt", op), n_ir, 1);
      check($sformatf("rnd op%0d bus_err cnt", op), n_err, 0);
   endtask

   initial begin
      int first_err, n_err, n_done, n_bad;
      ctl_t e;
      drive(1'b0, 6'd0, 1'b0, 1'b1);

      // ---------------- vector table ----------------
      add(0, 0, 0, 1, 0, 0);                       // reset, state not yet defined
      add(0, 0, 0, 1, 0, 1);                       // reset held
      add(1, 0, 0, 1, 0, 1); add(1, 0, 0, 1, 1, 1);   // R-type
      add(1, 0, 0, 1, 6, 1); add(1, 0, 0, 1, 7, 1);
      add(1, 35, 0, 1, 0, 1); add(1, 35, 0, 1, 1, 1); // lw, 2 waits
      add(1, 35, 0, 1, 2, 1); add(1, 35, 0, 0, 3, 1);
      add(1, 35, 0, 0, 3, 1); add(1, 35, 0, 1, 3, 1);
      add(1, 35, 0, 1, 4, 1);
      add(1, 4, 1, 1, 0, 1); add(1, 4, 1, 1, 1, 1); add(1, 4, 1, 1, 8, 1); // beq taken
      add(1, 4, 0, 1, 0, 1); add(1, 4, 0, 1, 1, 1); add(1, 4, 0, 1, 8, 1); // beq not taken
      add(1, 8, 0, 1, 0, 1); add(1, 8, 0, 1, 1, 1);   // addi
      add(1, 8, 0, 1, 9, 1); add(1, 8, 0, 1, 10, 1);
      add(1, 43, 0, 1, 0, 1); add(1, 43, 0, 1, 1, 1); // sw, 1 wait
      add(1, 43, 0, 1, 2, 1); add(1, 43, 0, 0, 5, 1);
      add(1, 43, 0, 1, 5, 1);
      add(1, 63, 0, 0, 0, 1); add(1, 63, 0, 1, 0, 1); // fetch wait, illegal op
      add(1, 63, 0, 1, 1, 1);
      add(1, 2, 0, 1, 0, 1); add(1, 2, 0, 1, 1, 1);   // opcode 2
`ifdef MIPS_CTRL_JUMP_EN
      add(1, 2, 0, 1, 11, 1);
`endif
      add(1, 0, 0, 1, 0, 1);
      add(0, 63, 0, 1, 1, 1);                      // reset in DECODE masks illegal_op
      add(1, 0, 0, 1, 0, 1);

      foreach (vecs[k]) begin
         drive(vecs[k].rst, vecs[k].op, vecs[k].z, vecs[k].rdy);
         sample();
         if (vecs[k].chk) begin
            e = spec_ctl(vecs[k].st, vecs[k].op, vecs[k].z, vecs[k].rdy, vecs[k].rst);
            check($sformatf("vec%0d state", k), act_st, vecs[k].st);
            check($sformatf("vec%0d ctl", k), int'(act), int'(e));
         end
         adv();
      end

      // ---------------- sw with memory stuck: abort on 16th MEMWR cycle ----------------
      do_reset();
      drive(1'b1, 6'd43, 1'b0, 1'b1);
      adv(); adv(); adv();                         // FETCH, DECODE, MEMADR
      bif.mem_ready = 1'b0;
      first_err = 0; n_err = 0; n_done = 0; n_bad = 0;
      for (int k = 1; k <= 16; k++) begin
         sample();
         if (act_st != 5) n_bad++;
         if (act.bus_err) begin n_err++; if (first_err == 0) first_err = k; end
         n_done += int'(act.instr_done) + int'(act.regwrite);
         adv();
      end
      sample();
      check("sw timeout state after abort", act_st, 0);
      check("sw timeout cycle of bus_err", first_err, 16);
      check("sw timeout bus_err count", n_err, 1);
      check("sw timeout no done/regwrite", n_done, 0);
      check("sw timeout stayed in MEMWR", n_bad, 0);

      // ---------------- lw: ready on the timeout cycle wins ----------------
      do_reset();
      drive(1'b1, 6'd35, 1'b0, 1'b1);
      adv(); adv(); adv();                         // FETCH, DECODE, MEMADR
      n_err = 0;
      for (int k = 1; k <= 16; k++) begin
         bif.mem_ready = (k == 16);
         sample();
         n_err += int'(act.bus_err);
         adv();
      end
      sample();
      check("lw ready-on-timeout no bus_err", n_err, 0);
      check("lw ready-on-timeout state MEMWB", act_st, 4);
      check("lw ready-on-timeout regwrite", int'(act.regwrite), 1);
      adv();

      // ---------------- FETCH stall: bus_err then retry ----------------
      do_reset();
      drive(1'b1, 6'd0, 1'b0, 1'b0);
      first_err = 0; n_err = 0; n_bad = 0;
      for (int k = 1; k <= 20; k++) begin
         sample();
         if (act_st != 0 || act.irwrite) n_bad++;
         if (act.bus_err) begin n_err++; if (first_err == 0) first_err = k; end
         adv();
      end
      check("fetch timeout cycle of bus_err", first_err, 16);
      check("fetch timeout bus_err count", n_err, 1);
      check("fetch timeout held in FETCH", n_bad, 0);
      bif.mem_ready = 1'b1;
      sample();
      check("fetch retry irwrite", int'(act.irwrite), 1);
      adv();
      sample();
      check("fetch retry reaches DECODE", act_st, 1);
      adv();

      // ---------------- randomized instructions ----------------
      do_reset();
      for (int n = 0; n < 200; n++) begin
         logic [5:0] op;
         int sel, wf, wm;
         sel = $urandom_range(0, 7);
         case (sel)
            0: op = 6'd0;  1: op = 6'd4;  2: op = 6'd8;
            3: op = 6'd35; 4: op = 6'd43; 5: op = 6'd2;
            default: op = 6'($urandom);
         endcase
         wf = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         wm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
         run_instr(op, 1'($urandom % 2), wf, wm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
